iob_im_sprites: RTL
===================

Name: iob_im_sprites

Overview:
Parametrised successor of the image memory renderer: draws N_OBJ rectangular objects over a programmable background colour.
- Each object has its own position, half-size, colour and enable.
- Object state is double-buffered (live/shadow); the CPU commits a new scene atomically at frame start, so no tearing.
- Sits between the CPU native bus and the VGA timing generator and feeds the RGB DAC through a 2-stage pixel pipeline.

Parameters:
DATA_W, 32, CPU data width
ADDR_W, 6, CPU word-address width
N_OBJ, 4, number of objects (1..16)
COORD_W, 10, pixel coordinate width
RGB_W, 12, colour width

Ports:
clk  in  1  clock
rst  in  1  asynchronous active-high reset
valid  in  1  CPU request
address  in  ADDR_W  CPU word address
wdata  in  DATA_W  write data
wstrb  in  DATA_W/8  byte strobes (any nonzero = write, whole word)
rdata  out  DATA_W  read data
ready  out  1  request done
im_pixel_x  in  COORD_W  current pixel column
im_pixel_y  in  COORD_W  current pixel row
im_pixel_valid  in  1  pixel in active area
im_frame_start  in  1  one-cycle pulse at start of frame
im_sw_input  in  32  board switches
im_rgb  out  RGB_W  pixel colour
im_rgb_valid  out  1  im_pixel_valid delayed 2 cycles

Behaviour:
- Reset (async, rst=1): all live and shadow registers, CTRL, BG, pending, FRAME_CNT, rdata, ready, im_rgb and im_rgb_valid go to 0.
- Register map (word address; all live unless noted):
  - 0 CTRL: bit0 global enable.
  - 1 BG: bits[RGB_W-1:0] background colour.
  - 2 COMMIT: any write sets pending.
  - 3 STATUS (RO): bit0 pending.
  - 4 FRAME_CNT (RO): 32-bit, wraps.
  - 5 SW (RO): im_sw_input.
  - 8+3i LOC_i: x=[COORD_W-1:0], y=[COORD_W+9:10].
  - 9+3i SIZE_i: hx=[7:0], hy=[15:8].
  - 10+3i ATTR_i: colour=[RGB_W-1:0], enable=bit31.
  - Reads of unmapped addresses return 0. Writes to RO or unmapped addresses are ignored.
- Bus handshake: ready=1 exactly one cycle after each valid cycle; rdata is registered with that same cycle. valid held for n cycles gives n ready pulses.
- Commit on im_frame_start:
  - FRAME_CNT increments.
  - If pending was 1 before this cycle: shadow <= live for all LOC/SIZE/ATTR, and pending clears.
  - A COMMIT write in the same cycle as im_frame_start sets pending and is applied at the next frame.
  - A LOC/SIZE/ATTR write in the frame_start cycle is not captured; shadow takes the pre-write live value.
  - CTRL and BG are not shadowed; they take effect immediately.
- Pixel pipeline:
  - Uses shadow registers only.
  - Stage 1 (registered): per-object hit = enable & x-hx <= px <= x+hx & y-hy <= py <= y+hy. Compare in COORD_W+2-bit signed arithmetic: no underflow wrap, so objects clip at the left/top edge, and x+hx beyond the screen is fine.
  - Stage 2 (registered): lowest-index hitting object wins. im_rgb = its colour; BG if none hit; 0 if the staged pixel_valid=0 or CTRL.enable=0.
  - Latency: pixel at cycle t appears at t+2. im_rgb_valid tracks the pipeline; throughput is 1 pixel per clock.
- Reset mid-frame: pipeline flushes to 0 immediately; output restarts 2 cycles after the first valid pixel following reset deassertion.

Test Plan:
1. Reset, then write obj0 LOC x=100 y=50, SIZE hx=7 hy=7, ATTR enable colour FFF, CTRL=1, BG=000, COMMIT, then pulse frame_start. Sweep row 50: im_rgb=FFF for x 93..107, 000 elsewhere, each 2 cycles after input; STATUS=0 after the pulse.
2. Overlap: obj0 colour F00, obj1 colour 0F0, both at (200,200), hx=hy=5, committed. Pixel (200,200) gives F00; disable obj0 and commit gives 0F0 after the next frame_start only; before that frame_start it stays F00.
3. Edge clip: obj2 x=2 hx=5, y=0 hy=3, BG=00F. Pixels (0,0)..(7,3) give obj colour; (8,0) gives 00F; (1023,0) gives 00F, with no wrap hit.
4. Tear-free: with a committed scene, write LOC_0 mid-frame without COMMIT. Output unchanged over 2 frames; STATUS=0. Write COMMIT in the same cycle as frame_start: STATUS=1 that frame, new position appears from the following frame.
5. Bus: read SW with im_sw_input=A5A5A5A5 gives rdata A5A5A5A5 with ready 1 cycle after valid. FRAME_CNT=3 after 3 pulses. Write to address 3 leaves STATUS unchanged; read of address 6 gives 0.
6. Assert rst mid-frame with im_pixel_valid=1: im_rgb and im_rgb_valid become 0 the same cycle; shadow, pending and FRAME_CNT read back 0.

Source files
------------

// File: rtl/iob_im_sprites.sv
// Sprite renderer: N_OBJ rectangles over a background colour. The CPU edits live registers
// and the scene is copied to shadow registers at frame start, feeding a 2-stage pixel pipeline.
module iob_im_sprites #(
  parameter int DATA_W  = 32,
  parameter int ADDR_W  = 6,
  parameter int N_OBJ   = 4,
  parameter int COORD_W = 10,
  parameter int RGB_W   = 12
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  valid,
  input  logic [ADDR_W-1:0]     address,
  input  logic [DATA_W-1:0]     wdata,
  input  logic [DATA_W/8-1:0]   wstrb,
  output logic [DATA_W-1:0]     rdata,
  output logic                  ready,
  input  logic [COORD_W-1:0]    im_pixel_x,
  input  logic [COORD_W-1:0]    im_pixel_y,
  input  logic                  im_pixel_valid,
  input  logic                  im_frame_start,
  input  logic [31:0]           im_sw_input,
  output logic [RGB_W-1:0]      im_rgb,
  output logic                  im_rgb_valid
);

  logic [COORD_W-1:0] live_x_r [N_OBJ];
  logic [COORD_W-1:0] live_y_r [N_OBJ];
  logic [7:0]         live_hx_r [N_OBJ];
  logic [7:0]         live_hy_r [N_OBJ];
  logic [RGB_W-1:0]   live_col_r [N_OBJ];
  logic [N_OBJ-1:0]   live_en_r;
  logic [COORD_W-1:0] shd_x_r [N_OBJ];
  logic [COORD_W-1:0] shd_y_r [N_OBJ];
  logic [7:0]         shd_hx_r [N_OBJ];
  logic [7:0]         shd_hy_r [N_OBJ];
  logic [RGB_W-1:0]   shd_col_r [N_OBJ];
  logic [N_OBJ-1:0]   shd_en_r;

  logic               ctrl_en_r;
  logic [RGB_W-1:0]   bg_r;
  logic               pending_r;
  logic [31:0]        frame_cnt_r;
  logic [DATA_W-1:0]  rdata_r;
  logic               ready_r;
  logic [N_OBJ-1:0]   hit1_r;
  logic               valid1_r;
  logic [RGB_W-1:0]   rgb2_r;
  logic               valid2_r;

  logic               wr_s;
  logic [DATA_W-1:0]  rd_s;
  logic [RGB_W-1:0]   pix_s;
  logic               unused_s;

  assign wr_s     = valid & (|wstrb);
  assign unused_s = ^wdata[DATA_W-2:COORD_W+10];

  // Widened signed arithmetic so x-h cannot wrap below zero and x+h can run past the screen.
  function automatic logic in_range_f(input logic [COORD_W-1:0] p, input logic [COORD_W-1:0] c,
                                      input logic [7:0] h);
    logic signed [COORD_W+1:0] p_e, lo, hi;
    p_e = $signed({2'b00, p});
    lo  = $signed({2'b00, c}) - $signed({{(COORD_W-6){1'b0}}, h});
    hi  = $signed({2'b00, c}) + $signed({{(COORD_W-6){1'b0}}, h});
    return (p_e >= lo) && (p_e <= hi);
  endfunction

  // Read data multiplexer
  always_comb begin
    rd_s = {DATA_W{1'b0}};
    case (address)
      ADDR_W'(0): rd_s[0] = ctrl_en_r;
      ADDR_W'(1): rd_s[RGB_W-1:0] = bg_r;
      ADDR_W'(3): rd_s[0] = pending_r;
      ADDR_W'(4): rd_s[31:0] = frame_cnt_r;
      ADDR_W'(5): rd_s[31:0] = im_sw_input;
      default: begin
        for (int i = 0; i < N_OBJ; i++) begin
          if (address == ADDR_W'(8 + 3*i)) begin
            rd_s[COORD_W-1:0]  = live_x_r[i];
            rd_s[COORD_W+9:10] = live_y_r[i];
          end else if (address == ADDR_W'(9 + 3*i)) begin
            rd_s[7:0]  = live_hx_r[i];
            rd_s[15:8] = live_hy_r[i];
          end else if (address == ADDR_W'(10 + 3*i)) begin
            rd_s[RGB_W-1:0] = live_col_r[i];
            rd_s[31]        = live_en_r[i];
          end else begin
            rd_s = rd_s;
          end
        end
      end
    endcase
  end

  // Bus response registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ready_r <= 1'b0;
      rdata_r <= {DATA_W{1'b0}};
    end else begin
      ready_r <= valid;
      rdata_r <= valid ? rd_s : {DATA_W{1'b0}};
    end
  end

  // Register file: live writes, frame counter and commit of live into shadow
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ctrl_en_r   <= 1'b0;
      bg_r        <= {RGB_W{1'b0}};
      pending_r   <= 1'b0;
      frame_cnt_r <= 32'd0;
      live_en_r   <= {N_OBJ{1'b0}};
      shd_en_r    <= {N_OBJ{1'b0}};
      for (int i = 0; i < N_OBJ; i++) begin
        live_x_r[i] <= {COORD_W{1'b0}};  shd_x_r[i] <= {COORD_W{1'b0}};
        live_y_r[i] <= {COORD_W{1'b0}};  shd_y_r[i] <= {COORD_W{1'b0}};
        live_hx_r[i] <= 8'd0;            shd_hx_r[i] <= 8'd0;
        live_hy_r[i] <= 8'd0;            shd_hy_r[i] <= 8'd0;
        live_col_r[i] <= {RGB_W{1'b0}};  shd_col_r[i] <= {RGB_W{1'b0}};
      end
    end else begin
      if (im_frame_start) begin
        frame_cnt_r <= frame_cnt_r + 32'd1;
        if (pending_r) begin
          shd_x_r   <= live_x_r;
          shd_y_r   <= live_y_r;
          shd_hx_r  <= live_hx_r;
          shd_hy_r  <= live_hy_r;
          shd_col_r <= live_col_r;
          shd_en_r  <= live_en_r;
          pending_r <= 1'b0;
        end
      end
      // A COMMIT landing with frame_start wins over the clear, so it applies next frame
      if (wr_s) begin
        case (address)
          ADDR_W'(0): ctrl_en_r <= wdata[0];
          ADDR_W'(1): bg_r      <= wdata[RGB_W-1:0];
          ADDR_W'(2): pending_r <= 1'b1;
          default: begin
            for (int i = 0; i < N_OBJ; i++) begin
              if (address == ADDR_W'(8 + 3*i)) begin
                live_x_r[i] <= wdata[COORD_W-1:0];
                live_y_r[i] <= wdata[COORD_W+9:10];
              end else if (address == ADDR_W'(9 + 3*i)) begin
                live_hx_r[i] <= wdata[7:0];
                live_hy_r[i] <= wdata[15:8];
              end else if (address == ADDR_W'(10 + 3*i)) begin
                live_col_r[i] <= wdata[RGB_W-1:0];
                live_en_r[i]  <= wdata[31];
              end
            end
          end
        endcase
      end
    end
  end

  // Lowest object index has priority
  always_comb begin
    pix_s = bg_r;
    for (int i = N_OBJ - 1; i >= 0; i--) begin
      if (hit1_r[i]) begin
        pix_s = shd_col_r[i];
      end else begin
        pix_s = pix_s;
      end
    end
  end

  // Pixel pipeline: stage 1 hit tests, stage 2 colour selection
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hit1_r   <= {N_OBJ{1'b0}};
      valid1_r <= 1'b0;
      rgb2_r   <= {RGB_W{1'b0}};
      valid2_r <= 1'b0;
    end else begin
      for (int i = 0; i < N_OBJ; i++) begin
        hit1_r[i] <= shd_en_r[i] & in_range_f(im_pixel_x, shd_x_r[i], shd_hx_r[i])
                                 & in_range_f(im_pixel_y, shd_y_r[i], shd_hy_r[i]);
      end
      valid1_r <= im_pixel_valid;
      valid2_r <= valid1_r;
      rgb2_r   <= (valid1_r & ctrl_en_r) ? pix_s : {RGB_W{1'b0}};
    end
  end

  assign rdata        = rdata_r;
  assign ready        = ready_r;
  assign im_rgb       = rgb2_r;
  assign im_rgb_valid = valid2_r;

endmodule
